// File: rtl/ddr4_v2_2_20_mc_cas_arb.sv
`default_nettype none
// ddr4_v2_2_20_mc_cas_arb: round-robin CAS arbiter for four group-FSM slots with tCCD and
// read/write turnaround spacing. Optional read priority with a write-starvation bound: DDR4_MC_CAS_ARB_RDPRIO_EN.
module ddr4_v2_2_20_mc_cas_arb #(
    parameter int TCCD_L       = 3,
    parameter int TCCD_S       = 2,
    parameter int TWTR         = 4,
    parameter int TRTW         = 3,
    parameter int CNTW         = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cmdReq,
    input  logic [3:0] cmdRd,
    input  logic [7:0] cmdGroup,
    input  logic       blockCas,
    output logic [3:0] sel,
    output logic       winValid,
    output logic       winRd
);

    localparam logic [CNTW:0] TCCD_L_W = (CNTW+1)'(TCCD_L);
    localparam logic [CNTW:0] TCCD_S_W = (CNTW+1)'(TCCD_S);
    localparam logic [CNTW:0] TWTR_W   = (CNTW+1)'(TWTR);
    localparam logic [CNTW:0] TRTW_W   = (CNTW+1)'(TRTW);

    logic [1:0]      rr_ptr;
    logic [1:0]      last_group;
    logic            last_rd;
    logic [CNTW-1:0] gap_cnt;

    logic [CNTW:0]   gap_next;
    logic [CNTW:0]   turn;
    logic [CNTW:0]   need;
    logic [3:0]      elig;
    logic [3:0]      cand;
    logic [1:0]      idx;
    logic [1:0]      win;
    logic            found;

    // The decision in this cycle lands one cycle later, hence the +1 on the gap.
    assign gap_next = {1'b0, gap_cnt} + (CNTW+1)'(1);
    assign turn     = last_rd ? TRTW_W : TWTR_W;

    always_comb begin
        elig = 4'b0;
        need = TCCD_S_W;
        for (int i = 0; i < 4; i++) begin
            need = (cmdGroup[2*i +: 2] == last_group) ? TCCD_L_W : TCCD_S_W;
            if ((cmdRd[i] != last_rd) && (turn > need))
                need = turn;
            elig[i] = cmdReq[i] && !blockCas && (gap_next >= need);
        end
    end

`ifdef DDR4_MC_CAS_ARB_RDPRIO_EN
    logic [3:0] starve_cnt;
    logic [3:0] rd_elig;
    logic       wr_pending;

    assign wr_pending = |(cmdReq & ~cmdRd);
    // Once the starvation bound is hit, reads drop out so the waiting write wins.
    assign rd_elig    = (starve_cnt == 4'(STARVE_LIMIT)) ? 4'b0 : (elig & cmdRd);
    assign cand       = (|rd_elig) ? rd_elig : (elig & ~cmdRd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (found) begin
            if (!cmdRd[win])
                starve_cnt <= 4'd0;
            else if (wr_pending && (starve_cnt != 4'hF))
                starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign cand = elig;
`endif

    // Work-conserving rotate search starting at rr_ptr.
    always_comb begin
        found = 1'b0;
        win   = rr_ptr;
        idx   = rr_ptr;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel        <= 4'b0;
            winValid   <= 1'b0;
            winRd      <= 1'b0;
            rr_ptr     <= 2'd0;
            last_group <= 2'd0;
            last_rd    <= 1'b1;
            gap_cnt    <= '1;
        end else begin
            sel      <= found ? (4'b0001 << win) : 4'b0;
            winValid <= found;
            winRd    <= found ? cmdRd[win] : 1'b0;
            if (found) begin
                rr_ptr     <= win + 2'd1;
                last_group <= cmdGroup[2*win +: 2];
                last_rd    <= cmdRd[win];
                gap_cnt    <= '0;
            end else if (gap_cnt != '1) begin
                gap_cnt <= gap_cnt + CNTW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr4_v2_2_20_mc_cas_arb.sv
`default_nettype none
// tb_ddr4_v2_2_20_mc_cas_arb: directed stimulus with a pulse-time reference model of the CAS arbiter.
module tb_ddr4_v2_2_20_mc_cas_arb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] cmdReq = 4'b0;
    logic [3:0] cmdRd = 4'b0;
    logic [7:0] cmdGroup = 8'b0;
    logic       blockCas = 1'b0;
    logic [3:0] sel;
    logic       winValid;
    logic       winRd;

    ddr4_v2_2_20_mc_cas_arb dut (
        .clk(clk), .rst_n(rst_n), .cmdReq(cmdReq), .cmdRd(cmdRd), .cmdGroup(cmdGroup),
        .blockCas(blockCas), .sel(sel), .winValid(winValid), .winRd(winRd)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int quota[4];
    int gcnt[4];
    bit rdv[4];
    int grpv[4];
    int cyc = 0;

    // Model state: cycle index of the last pulse instead of a counter.
    int m_last, m_ptr, m_grp, m_starve;
    bit m_rd;
    logic [3:0] p_sel;
    logic p_vld, p_rd;
    int log_slot[$];
    int log_cyc[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic m_reset();
        m_last = -100; m_ptr = 0; m_grp = 0; m_rd = 1'b1; m_starve = 0;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            cmdReq[i] = (quota[i] > gcnt[i]);
            cmdRd[i] = rdv[i];
            cmdGroup[2*i +: 2] = 2'(grpv[i]);
        end
    endtask

    task automatic decide();
        bit [3:0] el, cand;
        int best, g;
        bit wpend;
        drive_inputs();
        p_sel = 4'b0; p_vld = 1'b0; p_rd = 1'b0;
        if (!rst_n) begin
            m_reset();
            return;
        end
        el = 4'b0; wpend = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (cmdReq[i] && !cmdRd[i]) wpend = 1'b1;
            g = (int'(cmdGroup[2*i +: 2]) == m_grp) ? 3 : 2;
            if (cmdRd[i] != m_rd) g = m_rd ? ((g > 3) ? g : 3) : ((g > 4) ? g : 4);
            if (cmdReq[i] && !blockCas && (cyc + 1 - m_last >= g)) el[i] = 1'b1;
        end
        cand = el;
`ifdef DDR4_MC_CAS_ARB_RDPRIO_EN
        begin
            bit [3:0] rdel;
            rdel = (m_starve >= 8) ? 4'b0 : (el & cmdRd);
            cand = (rdel != 0) ? rdel : (el & ~cmdRd);
        end
`endif
        best = -1;
        for (int k = 0; k < 4; k++)
            if (best < 0 && cand[(m_ptr + k) % 4]) best = (m_ptr + k) % 4;
        if (best >= 0) begin
            p_sel = 4'(1 << best); p_vld = 1'b1; p_rd = cmdRd[best];
`ifdef DDR4_MC_CAS_ARB_RDPRIO_EN
            if (!cmdRd[best]) m_starve = 0;
            else if (wpend) m_starve++;
`endif
            m_last = cyc + 1;
            m_ptr = (best + 1) % 4;
            m_grp = int'(cmdGroup[2*best +: 2]);
            m_rd = cmdRd[best];
            log_slot.push_back(best);
            log_cyc.push_back(cyc + 1);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            decide();
            @(negedge clk);
            chk("sel", int'(sel), int'(p_sel));
            chk("winValid", int'(winValid), int'(p_vld));
            chk("winRd", int'(winRd), int'(p_rd));
            for (int i = 0; i < 4; i++) if (p_sel[i]) gcnt[i]++;
            cyc++;
        end
    endtask

    task automatic set_req(input int s, input int n, input bit rd, input int grp);
        quota[s] = gcnt[s] + n; rdv[s] = rd; grpv[s] = grp;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) quota[i] = gcnt[i];
        tick(2);
        rst_n = 1'b1;
        log_slot.delete();
        log_cyc.delete();
    endtask

    task automatic run_until(input string name, input int n, input int budget);
        int k = 0;
        while (log_slot.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        tick(1);
        chk(name, (log_slot.size() >= n) ? 1 : 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            quota[i] = 0; gcnt[i] = 0; rdv[i] = 1'b1; grpv[i] = 0;
        end
        m_reset();
        do_reset();

        // Single read right after reset: one pulse, next cycle, one cycle wide.
        set_req(0, 1, 1'b1, 0);
        tick(1);
        chk("t1_sel", int'(sel), 1);
        chk("t1_valid", int'(winValid), 1);
        tick(1);
        chk("t1_sel_off", int'(sel), 0);
        chk("t1_valid_off", int'(winValid), 0);

        // Four reads, distinct groups: rotation every TCCD_S.
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 2, 1'b1, i);
        run_until("t2_timeout", 8, 40);
        for (int i = 0; i < 8; i++) begin
            chk("t2_slot", log_slot[i], i % 4);
            if (i > 0) chk("t2_gap", log_cyc[i] - log_cyc[i-1], 2);
        end

        // Same bank group: TCCD_L spacing.
        do_reset();
        set_req(0, 2, 1'b1, 2);
        set_req(1, 2, 1'b1, 2);
        run_until("t3_timeout", 4, 40);
        for (int i = 1; i < 4; i++) chk("t3_gap", log_cyc[i] - log_cyc[i-1], 3);

        // Read -> write (TRTW), then write -> read (TWTR).
        do_reset();
        set_req(0, 1, 1'b1, 0);
        run_until("t4a_timeout", 1, 20);
        set_req(1, 1, 1'b0, 1);
        run_until("t4b_timeout", 2, 20);
        set_req(2, 1, 1'b1, 2);
        run_until("t4c_timeout", 3, 20);
        chk("t4_rtw_gap", log_cyc[1] - log_cyc[0], 3);
        chk("t4_wtr_gap", log_cyc[2] - log_cyc[1], 4);

        // blockCas inhibit, release, then async reset while a pulse is high.
        do_reset();
        blockCas = 1'b1;
        set_req(2, 1, 1'b1, 0);
        tick(5);
        chk("t5_blocked", log_slot.size(), 0);
        blockCas = 1'b0;
        tick(1);
        chk("t5_sel_after_block", int'(sel), 4);
        rst_n = 1'b0;
        #1;
        chk("t5_async_rst_sel", int'(sel), 0);
        chk("t5_async_rst_valid", int'(winValid), 0);
        tick(2);
        rst_n = 1'b1;
        log_slot.delete();
        log_cyc.delete();
        set_req(2, 1, 1'b1, 0);
        set_req(3, 1, 1'b1, 1);
        run_until("t5_restart_timeout", 2, 20);
        chk("t5_restart_first", log_slot[0], 2);
        chk("t5_restart_second", log_slot[1], 3);

        // Continuous reads on slots 0/1 against one pending write on slot 2.
        do_reset();
        set_req(0, 10, 1'b1, 0);
        set_req(1, 10, 1'b1, 0);
        set_req(2, 1, 1'b0, 1);
`ifdef DDR4_MC_CAS_ARB_RDPRIO_EN
        run_until("t6_timeout", 9, 60);
        for (int i = 0; i < 8; i++) chk("t6_read_slot", log_slot[i], i % 2);
        chk("t6_write_slot", log_slot[8], 2);
        chk("t6_write_gap", log_cyc[8] - log_cyc[7], 3);
`else
        run_until("t6_timeout", 3, 30);
        chk("t6_write_slot", log_slot[2], 2);
        chk("t6_write_gap", log_cyc[2] - log_cyc[1], 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
